// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_pkg
//  Description : Shared constants for the commit-side trap controller:
//                exception cause codes, interrupt cause codes, privilege
//                mode encodings and the trap FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package trap_ctrl_pkg;

    // Synchronous exception cause codes
    localparam logic [3:0] c_exc_i_addr_misaligned = 4'd0;
    localparam logic [3:0] c_exc_i_illegal         = 4'd2;
    localparam logic [3:0] c_exc_breakpoint        = 4'd3;
    localparam logic [3:0] c_exc_ecall_u           = 4'd8;
    localparam logic [3:0] c_exc_ecall_s           = 4'd9;
    localparam logic [3:0] c_exc_ecall_m           = 4'd11;

    // Interrupt cause codes
    localparam logic [3:0] c_irq_mei = 4'd11;
    localparam logic [3:0] c_irq_mti = 4'd7;
    localparam logic [3:0] c_irq_sei = 4'd9;
    localparam logic [3:0] c_irq_sti = 4'd5;

    // Privilege mode encodings as delivered by the CSR file
    localparam logic [1:0] c_mode_u = 2'd0;
    localparam logic [1:0] c_mode_s = 2'd1;
    localparam logic [1:0] c_mode_m = 2'd3;

    // Trap FSM state encoding
    typedef logic [1:0] trap_state_t;
    localparam trap_state_t c_st_idle     = 2'd0;
    localparam trap_state_t c_st_event    = 2'd1;
    localparam trap_state_t c_st_redirect = 2'd2;

    // ECALL cause depends on the mode the call is made from
    function automatic logic [3:0] ecall_code(input logic [1:0] mode);
        case (mode)
            c_mode_u: ecall_code = c_exc_ecall_u;
            c_mode_s: ecall_code = c_exc_ecall_s;
            default:  ecall_code = c_exc_ecall_m;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Fixed-priority interrupt encoder. Bit order of the vectors
//                is [3]=MEI, [2]=MTI, [1]=SEI, [0]=STI, highest bit wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc
    import trap_ctrl_pkg::*;
(
    input  logic [3:0] i_pending,
    input  logic [3:0] i_enable,
    output logic       o_valid,
    output logic [3:0] o_code
);

    logic [3:0] w_active;

    assign w_active = i_pending & i_enable;
    assign o_valid  = |w_active;

    // Pick the highest-priority enabled source
    always_comb begin
        o_code = 4'd0;
        if (w_active[3])      o_code = c_irq_mei;
        else if (w_active[2]) o_code = c_irq_mti;
        else if (w_active[1]) o_code = c_irq_sei;
        else if (w_active[0]) o_code = c_irq_sti;
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Commit-side trap/return controller. Arbitrates exceptions,
//                ECALL/EBREAK, MRET/SRET and interrupts on the retiring
//                instruction, emits a one-cycle event to the CSR file and
//                holds flush until the frontend acknowledges the redirect.
//  Options     : TRAP_IRQ_SYNC_EN - 2-flop synchronizers on m_interrupt and
//                s_interrupt (timers are never synchronized).
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [31:0]     ex_instr,
    input  logic            ex_exc_valid,
    input  logic [3:0]      ex_exc_code,
    input  logic            ex_ecall,
    input  logic            ex_ebreak,
    input  logic            ex_mret,
    input  logic            ex_sret,
    input  logic [1:0]      current_mode,
    input  logic            m_eie,
    input  logic            m_tie,
    input  logic            s_eie,
    input  logic            s_tie,
    input  logic            m_interrupt,
    input  logic            s_interrupt,
    input  logic            m_timer,
    input  logic            s_timer,
    input  logic            fe_ack,
    output logic            exception_pending,
    output logic [XLEN-1:0] m_cause,
    output logic [XLEN-1:0] pc_exc,
    output logic [31:0]     instruction_word,
    output logic            m_ret,
    output logic            s_ret,
    output logic            u_ret,
    output logic            flush,
    output logic            trap_busy
);

    localparam logic [3:0] c_cnt_thr = 4'(FLUSH_CYCLES - 1);

    trap_state_t     r_state;
    logic [3:0]      r_cnt;
    logic            r_ack_seen;
    logic            r_pending;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_mret;
    logic            r_sret;

    logic            w_m_int;
    logic            w_s_int;
    logic            w_irq_valid;
    logic [3:0]      w_irq_code;
    logic            w_commit;
    logic            w_event;
    logic [XLEN-1:0] w_cause;
    logic            w_mret;
    logic            w_sret;
    logic [3:0]      w_cnt_inc;
    logic            w_ack;

`ifdef TRAP_IRQ_SYNC_EN
    logic [1:0] r_m_int_sync;
    logic [1:0] r_s_int_sync;

    // Bring the asynchronous external interrupt lines into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_int_sync <= 2'b00;
            r_s_int_sync <= 2'b00;
        end else begin
            r_m_int_sync <= {r_m_int_sync[0], m_interrupt};
            r_s_int_sync <= {r_s_int_sync[0], s_interrupt};
        end
    end

    assign w_m_int = r_m_int_sync[1];
    assign w_s_int = r_s_int_sync[1];
`else
    assign w_m_int = m_interrupt;
    assign w_s_int = s_interrupt;
`endif

    irq_prio_enc u_irq_prio_enc (
        .i_pending ({w_m_int, m_timer, w_s_int, s_timer}),
        .i_enable  ({m_eie,   m_tie,   s_eie,   s_tie}),
        .o_valid   (w_irq_valid),
        .o_code    (w_irq_code)
    );

    // Only an unstalled valid instruction seen while idle can raise an event
    assign w_commit  = ex_valid && !stall && (r_state == c_st_idle);
    assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    // A frontend ack seen in EVENT or early REDIRECT stays remembered
    assign w_ack     = fe_ack || r_ack_seen;

    // Event arbitration on the retiring instruction, highest priority first
    always_comb begin
        w_event = 1'b0;
        w_cause = '0;
        w_mret  = 1'b0;
        w_sret  = 1'b0;
        if (ex_exc_valid) begin
            w_event = 1'b1;
            w_cause = {{(XLEN-4){1'b0}}, ex_exc_code};
        end else if (ex_mret && (current_mode != c_mode_m)) begin
            w_event = 1'b1;
            w_cause = {{(XLEN-4){1'b0}}, c_exc_i_illegal};
        end else if (ex_sret && (current_mode == c_mode_u)) begin
            w_event = 1'b1;
            w_cause = {{(XLEN-4){1'b0}}, c_exc_i_illegal};
        end else if (ex_ebreak) begin
            w_event = 1'b1;
            w_cause = {{(XLEN-4){1'b0}}, c_exc_breakpoint};
        end else if (ex_ecall) begin
            w_event = 1'b1;
            w_cause = {{(XLEN-4){1'b0}}, ecall_code(current_mode)};
        end else if (ex_mret) begin
            w_event = 1'b1;
            w_mret  = 1'b1;
        end else if (ex_sret) begin
            w_event = 1'b1;
            w_sret  = 1'b1;
        end else if (w_irq_valid) begin
            w_event = 1'b1;
            w_cause = {1'b1, {(XLEN-5){1'b0}}, w_irq_code};
        end
    end

    // Trap FSM, flush counter and registered event outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_cnt      <= 4'd0;
            r_ack_seen <= 1'b0;
            r_pending  <= 1'b0;
            r_cause    <= '0;
            r_pc       <= '0;
            r_instr    <= 32'd0;
            r_mret     <= 1'b0;
            r_sret     <= 1'b0;
        end else begin
            r_pending <= 1'b0;
            r_mret    <= 1'b0;
            r_sret    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_commit && w_event) begin
                        r_state    <= c_st_event;
                        r_cnt      <= 4'd0;
                        r_ack_seen <= 1'b0;
                        r_pending  <= 1'b1;
                        r_cause    <= w_cause;
                        r_pc       <= ex_pc;
                        r_instr    <= ex_instr;
                        r_mret     <= w_mret;
                        r_sret     <= w_sret;
                    end
                end
                c_st_event: begin
                    r_state    <= c_st_redirect;
                    r_cnt      <= w_cnt_inc;
                    r_ack_seen <= w_ack;
                end
                c_st_redirect: begin
                    if (w_ack && (r_cnt >= c_cnt_thr)) begin
                        r_state    <= c_st_idle;
                        r_ack_seen <= 1'b0;
                    end else begin
                        r_cnt      <= w_cnt_inc;
                        r_ack_seen <= w_ack;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign exception_pending = r_pending;
    assign m_cause           = r_cause;
    assign pc_exc            = r_pc;
    assign instruction_word  = r_instr;
    assign m_ret             = r_mret;
    assign s_ret             = r_sret;
    assign u_ret             = 1'b0;
    assign flush             = (r_state != c_st_idle);
    assign trap_busy         = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trap_ctrl
//  Description : Scoreboard bench for trap_ctrl. Stimulus pushes the expected
//                event per trapping commit; a monitor pops and compares each
//                time exception_pending is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    localparam int XLEN         = 32;
    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, stall;
    logic [31:0] ex_pc, ex_instr;
    logic        ex_exc_valid;
    logic [3:0]  ex_exc_code;
    logic        ex_ecall, ex_ebreak, ex_mret, ex_sret;
    logic [1:0]  current_mode;
    logic        m_eie, m_tie, s_eie, s_tie;
    logic        m_interrupt, s_interrupt, m_timer, s_timer;
    logic        fe_ack;
    logic        exception_pending;
    logic [31:0] m_cause, pc_exc, instruction_word;
    logic        m_ret, s_ret, u_ret, flush, trap_busy;

    typedef struct {
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mret;
        logic        sret;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    trap_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_valid          (ex_valid),
        .stall             (stall),
        .ex_pc             (ex_pc),
        .ex_instr          (ex_instr),
        .ex_exc_valid      (ex_exc_valid),
        .ex_exc_code       (ex_exc_code),
        .ex_ecall          (ex_ecall),
        .ex_ebreak         (ex_ebreak),
        .ex_mret           (ex_mret),
        .ex_sret           (ex_sret),
        .current_mode      (current_mode),
        .m_eie             (m_eie),
        .m_tie             (m_tie),
        .s_eie             (s_eie),
        .s_tie             (s_tie),
        .m_interrupt       (m_interrupt),
        .s_interrupt       (s_interrupt),
        .m_timer           (m_timer),
        .s_timer           (s_timer),
        .fe_ack            (fe_ack),
        .exception_pending (exception_pending),
        .m_cause           (m_cause),
        .pc_exc            (pc_exc),
        .instruction_word  (instruction_word),
        .m_ret             (m_ret),
        .s_ret             (s_ret),
        .u_ret             (u_ret),
        .flush             (flush),
        .trap_busy         (trap_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %08h required %08h", name, act, req);
    endtask

    // Drive one instruction for a single clock edge, then drop it
    task automatic commit(input logic [31:0] pc, input logic [31:0] instr,
                          input logic exc, input logic [3:0] code,
                          input logic ecall, input logic ebreak,
                          input logic mret, input logic sret,
                          input logic [1:0] mode);
        ex_valid     = 1'b1;
        ex_pc        = pc;
        ex_instr     = instr;
        ex_exc_valid = exc;
        ex_exc_code  = code;
        ex_ecall     = ecall;
        ex_ebreak    = ebreak;
        ex_mret      = mret;
        ex_sret      = sret;
        current_mode = mode;
        @(posedge clk); #1;
        ex_valid     = 1'b0;
        ex_exc_valid = 1'b0;
        ex_exc_code  = 4'd0;
        ex_ecall     = 1'b0;
        ex_ebreak    = 1'b0;
        ex_mret      = 1'b0;
        ex_sret      = 1'b0;
    endtask

    task automatic expect_event(input logic [31:0] cause, input logic [31:0] pc,
                                input logic [31:0] instr, input logic mret,
                                input logic sret);
        exp_t e;
        e.cause = cause; e.pc = pc; e.instr = instr; e.mret = mret; e.sret = sret;
        sb.push_back(e);
    endtask

    // Called right after the event edge. Early ack is a single-cycle pulse in
    // EVENT; otherwise fe_ack rises ack_delay cycles after the event.
    task automatic run_redirect(input bit early_ack, input int ack_delay);
        int cyc = 0;
        int fl  = 0;
        check("flush_in_event", {31'd0, flush}, 32'd1);
        if (early_ack) fe_ack = 1'b1;
        while (trap_busy && cyc < 40) begin
            if (flush) fl++;
            @(posedge clk); #1;
            cyc++;
            fe_ack = (!early_ack && cyc >= ack_delay);
        end
        fe_ack = 1'b0;
        check("redirect_done", {31'd0, trap_busy}, 32'd0);
        check("flush_cycles", fl, early_ack ? 32'd2 : 32'(ack_delay + 1));
        check("flush_released", {31'd0, flush}, 32'd0);
    endtask

    // Monitor: every event pulse is matched against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exception_pending === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_event: got pending cause %08h pc %08h, required no event",
                             m_cause, pc_exc);
                end else begin
                    e = sb.pop_front();
                    check("m_cause", m_cause, e.cause);
                    check("pc_exc", pc_exc, e.pc);
                    check("instruction_word", instruction_word, e.instr);
                    check("m_ret", {31'd0, m_ret}, {31'd0, e.mret});
                    check("s_ret", {31'd0, s_ret}, {31'd0, e.sret});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; stall = 1'b0; ex_pc = 32'd0; ex_instr = 32'd0;
        ex_exc_valid = 1'b0; ex_exc_code = 4'd0; ex_ecall = 1'b0; ex_ebreak = 1'b0;
        ex_mret = 1'b0; ex_sret = 1'b0; current_mode = 2'd3;
        m_eie = 1'b0; m_tie = 1'b0; s_eie = 1'b0; s_tie = 1'b0;
        m_interrupt = 1'b0; s_interrupt = 1'b0; m_timer = 1'b0; s_timer = 1'b0;
        fe_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_pending", {31'd0, exception_pending}, 32'd0);
        check("rst_cause", m_cause, 32'd0);
        check("rst_pc", pc_exc, 32'd0);
        check("rst_flush", {31'd0, flush}, 32'd0);
        check("rst_busy", {31'd0, trap_busy}, 32'd0);
        check("rst_u_ret", {31'd0, u_ret}, 32'd0);

        // Illegal instruction at 0x100, late ack
        expect_event(32'h2, 32'h100, 32'hFFFF_FFFF, 1'b0, 1'b0);
        commit(32'h100, 32'hFFFF_FFFF, 1'b1, 4'd2, 0, 0, 0, 0, 2'd3);
        run_redirect(1'b0, 3);

        // ECALL from S with early ack, ECALL from M
        expect_event(32'd9, 32'h200, 32'h0000_0073, 1'b0, 1'b0);
        commit(32'h200, 32'h0000_0073, 0, 4'd0, 1, 0, 0, 0, 2'd1);
        run_redirect(1'b1, 0);
        expect_event(32'd11, 32'h204, 32'h0000_0073, 1'b0, 1'b0);
        commit(32'h204, 32'h0000_0073, 0, 4'd0, 1, 0, 0, 0, 2'd3);
        run_redirect(1'b0, 1);

        // Returns: legal MRET, MRET from U, legal SRET, EBREAK
        expect_event(32'd0, 32'h208, 32'h3020_0073, 1'b1, 1'b0);
        commit(32'h208, 32'h3020_0073, 0, 4'd0, 0, 0, 1, 0, 2'd3);
        run_redirect(1'b0, 1);
        expect_event(32'd2, 32'h20C, 32'h3020_0073, 1'b0, 1'b0);
        commit(32'h20C, 32'h3020_0073, 0, 4'd0, 0, 0, 1, 0, 2'd0);
        run_redirect(1'b0, 1);
        expect_event(32'd0, 32'h210, 32'h1020_0073, 1'b0, 1'b1);
        commit(32'h210, 32'h1020_0073, 0, 4'd0, 0, 0, 0, 1, 2'd1);
        run_redirect(1'b0, 1);
        expect_event(32'd3, 32'h214, 32'h0010_0073, 1'b0, 1'b0);
        commit(32'h214, 32'h0010_0073, 0, 4'd0, 0, 1, 0, 0, 2'd3);
        run_redirect(1'b0, 1);

        // Interrupt priority: MTI over SEI, then SEI once MTI clears
        m_timer = 1'b1; m_tie = 1'b1; s_interrupt = 1'b1; s_eie = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_event(32'h8000_0007, 32'h300, 32'h0000_0013, 1'b0, 1'b0);
        commit(32'h300, 32'h0000_0013, 0, 4'd0, 0, 0, 0, 0, 2'd3);
        run_redirect(1'b0, 1);
        m_timer = 1'b0;
        expect_event(32'h8000_0009, 32'h304, 32'h0000_0013, 1'b0, 1'b0);
        commit(32'h304, 32'h0000_0013, 0, 4'd0, 0, 0, 0, 0, 2'd3);
        run_redirect(1'b0, 1);
        s_interrupt = 1'b0; s_eie = 1'b0; m_tie = 1'b0;

        // Stalled commit with a pending interrupt: nothing happens
        m_interrupt = 1'b1; m_eie = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stall = 1'b1;
        commit(32'h350, 32'h0000_0073, 0, 4'd0, 1, 0, 0, 0, 2'd3);
        check("stall_busy", {31'd0, trap_busy}, 32'd0);
        stall = 1'b0;

        // Illegal wins over MEI; MEI is taken at the next commit
        expect_event(32'd2, 32'h400, 32'hDEAD_BEEF, 1'b0, 1'b0);
        commit(32'h400, 32'hDEAD_BEEF, 1'b1, 4'd2, 0, 0, 0, 0, 2'd3);
        run_redirect(1'b0, 2);
        repeat (2) @(posedge clk);
        #1;
        expect_event(32'h8000_000B, 32'h404, 32'h0000_0013, 1'b0, 1'b0);
        commit(32'h404, 32'h0000_0013, 0, 4'd0, 0, 0, 0, 0, 2'd3);
        run_redirect(1'b0, 1);
        m_interrupt = 1'b0; m_eie = 1'b0;

        // Reset in REDIRECT without ack drops the trap
        expect_event(32'd2, 32'h500, 32'h1234_5678, 1'b0, 1'b0);
        commit(32'h500, 32'h1234_5678, 1'b1, 4'd2, 0, 0, 0, 0, 2'd3);
        repeat (2) @(posedge clk);
        #1;
        check("redirect_hold", {31'd0, flush}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_flush", {31'd0, flush}, 32'd0);
        check("rst_mid_busy", {31'd0, trap_busy}, 32'd0);
        check("rst_mid_cause", m_cause, 32'd0);
        check("rst_mid_pc", pc_exc, 32'd0);
        check("rst_mid_instr", instruction_word, 32'd0);
        expect_event(32'd8, 32'h600, 32'h0000_0073, 1'b0, 1'b0);
        commit(32'h600, 32'h0000_0073, 0, 4'd0, 1, 0, 0, 0, 2'd0);
        run_redirect(1'b0, 1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
